// File: rtl/fib_seq_if.sv
// Purpose : request/response and ALU-operand bundle for the Fibonacci sequencer.
// Latency : none, wires only.
// Backpressure: none. The requester observes busy and done itself.
// Ports   : master = requester plus ALU side (drives start, n, alu_s).
//           slave  = fib_seq (drives alu_a, alu_b, alu_mode, busy, done, result, ovf).
interface fib_seq_if #(
    parameter int N_W = 4
);
    logic           start;
    logic [N_W-1:0] n;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [3:0]     alu_mode;
    logic [7:0]     alu_s;
    logic           busy;
    logic           done;
    logic [7:0]     result;
    logic           ovf;

    modport master (
        output start, n, alu_s,
        input  alu_a, alu_b, alu_mode, busy, done, result, ovf
    );

    modport slave (
        input  start, n, alu_s,
        output alu_a, alu_b, alu_mode, busy, done, result, ovf
    );
endinterface

// File: rtl/fib_seq.sv
// Purpose : computes F(n) mod 256 plus an overflow flag by iterating an external 8-bit ALU.
// Latency : done pulses in the cycle after edge E0+n, where E0 is the start edge (E0 itself when n==0).
// Backpressure: start is taken only in IDLE. start or n changes while busy or in DONE are ignored.
// Ports   : clk and rst (synchronous, active-high); bus is the fib_seq_if.slave modport
//           carrying start/n, the ALU operands and result, and busy/done/result/ovf.
module fib_seq #(
    parameter int N_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    fib_seq_if.slave   bus
);

    localparam logic [3:0] MODE_ADD = 4'b0011;
    localparam logic [3:0] MODE_CLR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     fa;
    logic [7:0]     fb;
    logic [N_W-1:0] cnt;
    logic           wa;
    logic           wb;
    logic [7:0]     result_q;
    logic           ovf_q;
    logic           carry;
    logic           last_iter;

    // An 8-bit add wrapped exactly when the sum is smaller than one of its operands.
    assign carry     = (bus.alu_s < fb);
    assign last_iter = (cnt == N_W'(1));

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

    always_comb begin
        state_d      = state_q;
        bus.alu_a    = 8'd0;
        bus.alu_b    = 8'd0;
        bus.alu_mode = MODE_CLR;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.n == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                bus.alu_a    = fa;
                bus.alu_b    = fb;
                bus.alu_mode = MODE_ADD;
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fa       <= 8'd0;
            fb       <= 8'd0;
            cnt      <= '0;
            wa       <= 1'b0;
            wb       <= 1'b0;
            result_q <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        fa  <= 8'd0;
                        fb  <= 8'd1;
                        wa  <= 1'b0;
                        wb  <= 1'b0;
                        cnt <= bus.n;
                        // F(0) goes straight to DONE, so the result is loaded here.
                        if (bus.n == '0) begin
                            result_q <= 8'd0;
                            ovf_q    <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    fa  <= fb;
                    fb  <= bus.alu_s;
                    wa  <= wb;
                    // Once any term has wrapped, every later term is also too large.
                    wb  <= wa | wb | carry;
                    cnt <= cnt - N_W'(1);
                    // fb and wb are the values fa and wa take on this edge, i.e. F(n).
                    // The overflow of F(n+1), now landing in fb, is intentionally dropped.
                    if (last_iter) begin
                        result_q <= fb;
                        ovf_q    <= wb;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq.sv
module tb_fib_seq;

    localparam logic [3:0] ADD = 4'b0011;
    localparam logic [3:0] CLR = 4'b1010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    int   exp_res = 0;
    int   exp_ovf = 0;

    fib_seq_if #(.N_W(4)) bus ();

    fib_seq #(.N_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Downstream ALU: 8-bit wrapping add, or clear.
    assign bus.alu_s = (bus.alu_mode == ADD) ? (bus.alu_a + bus.alu_b) : 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: the true Fibonacci number computed at full width.
    function automatic longint fib(input int k);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("alu_mode_legal", 32'(bus.alu_mode == ADD || bus.alu_mode == CLR), 32'd1);
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_mode", 32'(bus.alu_mode), 32'(CLR));
            chk("idle_result_hold", 32'(bus.result), 32'(exp_res));
            chk("idle_ovf_hold", 32'(bus.ovf), 32'(exp_ovf));
        end
    endtask

    // Entered at a negedge, in IDLE or in the DONE cycle of the previous job.
    task automatic run(input int nn, input bit noise);
        int     c = 0;
        int     iters = 0;
        longint f;
        bus.start = 1'b1;
        bus.n     = 4'(nn);
        if (bus.done) begin
            @(negedge clk);
            chk("done_start_ignored", 32'(bus.busy), 32'd0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && c < 40) begin
            if (bus.alu_mode == ADD) iters++;
            chk("busy_in_iter", 32'(bus.busy), 32'd1);
            if (noise) begin
                bus.start = 1'($urandom);
                bus.n     = 4'($urandom);
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        f       = fib(nn);
        exp_res = int'(f % 256);
        exp_ovf = (f > 255) ? 1 : 0;
        chk("latency", 32'(c), 32'(nn));
        chk("iter_cycles", 32'(iters), 32'(nn));
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        chk("result", 32'(bus.result), 32'(exp_res));
        chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.n     = 4'd0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_mode", 32'(bus.alu_mode), 32'(CLR));
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Directed corner cases.
        run(0, 1'b0);
        idle(1);
        run(10, 1'b0);
        idle(2);
        run(13, 1'b0);
        run(14, 1'b0);
        idle(1);
        run(15, 1'b0);
        idle(1);
        run(5, 1'b1);
        run(9, 1'b0);
        idle(1);

        // Reset in the 4th ITER cycle of an n=12 job.
        bus.start = 1'b1;
        bus.n     = 4'd12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_iter", 32'(bus.alu_mode), 32'(ADD));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        chk("abort_mode", 32'(bus.alu_mode), 32'(CLR));
        chk("abort_alu_a", 32'(bus.alu_a), 32'd0);
        exp_res = 0;
        exp_ovf = 0;
        idle(15);

        // Reset wins over a simultaneous start.
        run(7, 1'b0);
        idle(1);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.n     = 4'd6;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        exp_res   = 0;
        exp_ovf   = 0;
        chk("rst_vs_start_busy", 32'(bus.busy), 32'd0);
        idle(3);

        // Randomized jobs with busy-time noise and random back-to-back starts.
        for (int i = 0; i < 30; i++) begin
            run(int'($urandom_range(0, 15)), 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
